// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and sizing helper for the button debouncer
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/level_synchronizer.sv
// rtl/level_synchronizer.sv - multi-flop synchroniser for an asynchronous level
module level_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise and debounce a bouncing input into a clean level
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                level,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            s;
    debounce_state_t state;
    logic [CW-1:0]   cnt;

    level_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (raw_in),
        .q    (s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE_LOW;
            cnt          <= '0;
            level        <= 1'b0;
            glitch_count <= '0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        // A bounce throws away all accumulated credit.
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        if (glitch_count != '1) glitch_count <= glitch_count + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        if (glitch_count != '1) glitch_count <= glitch_count + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    assign settling = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with directed vectors
module tb_button_debouncer;

    localparam int GW = 2;

    typedef struct packed {
        logic          rst;
        logic          raw;
        logic          chk;
        logic          lvl;
        logic          set;
        logic [GW-1:0] gl;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          raw_in;
    logic          level;
    logic          settling;
    logic [GW-1:0] glitch_count;

    vec_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   done       = 1'b0;

    button_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .GLITCH_W     (GW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .level       (level),
        .settling    (settling),
        .glitch_count(glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs and queue what the outputs must be after that edge.
    task automatic step(input logic r, input logic rw, input logic l, input logic st, input int g);
        vec_t v;
        @(negedge clk);
        reset  = r;
        raw_in = rw;
        v.rst = r;
        v.raw = rw;
        v.chk = 1'b1;
        v.lvl = l;
        v.set = st;
        v.gl  = GW'(g);
        q.push_back(v);
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after it.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    compared++;
                    if (level !== e.lvl || settling !== e.set || glitch_count !== e.gl) begin
                        mismatched++;
                        $display("FAIL outputs#%0d: got level=%b settling=%b glitch=%0d, want level=%b settling=%b glitch=%0d",
                                 compared, level, settling, glitch_count, e.lvl, e.set, e.gl);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: run did not complete, want completion");
            $fatal(1, "timeout");
        end
    end

    initial begin
        int gl_exp;
        int set_exp;
        logic rw;
        reset  = 1'b0;
        raw_in = 1'b0;

        // Reset held with raw_in high
        repeat (3) step(0, 1, 0, 0, 0);

        // Clean rise: level after edge 6, settling on edges 3..5
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        // Clean fall
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Bounce: 1,1,0 then 1 stable; abort on edge 5, rise on edge 9
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);

        // Reset from the high state clears everything
        step(0, 0, 0, 0, 0);

        // Saturation: pulses on edges 1,4,7,10,13 abort on edges 4,7,10,13,16
        for (int k = 1; k <= 16; k++) begin
            rw      = (k <= 13) && ((k - 1) % 3 == 0);
            gl_exp  = ((k - 1) / 3 > 3) ? 3 : (k - 1) / 3;
            set_exp = ((k % 3 == 0) && (k <= 15)) ? 1 : 0;
            step(1, rw, 0, set_exp[0], gl_exp);
        end

        // Reset while timing a rise (cnt == 2)
        step(1, 1, 0, 0, 3);
        step(1, 1, 0, 0, 3);
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 1, 3);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #2;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
